// File: rtl/multi_dataflow_engine.sv
// Dataflow engine wrapper: sequences a kernel job and bridges streamer <-> kernel streams.
// Latency: start -> kernel start 1 cycle; last beat + kernel done -> done pulse 1 cycle; streams combinational.
// Backpressure: ready/valid pass through in RUN only; output is cut off once the job limit is reached.

package multi_dataflow_engine_pkg;
  localparam int CNT_LEN = 1024;
  localparam int CW      = $clog2(CNT_LEN) + 1;

  typedef struct packed {
    logic          clear;
    logic          enable;
    logic          start;
    logic [CW-1:0] cnt_limit_out_pel;
  } ctrl_engine_t;

  typedef struct packed {
    logic [CW-1:0] cnt_out_pel;
    logic          done;
    logic          ready;
  } flags_engine_t;

  typedef struct packed {
    logic start;
  } ctrl_kernel_adapter_t;

  typedef struct packed {
    logic done;
    logic idle;
    logic ready;
  } flags_kernel_adapter_t;
endpackage

module multi_dataflow_engine
  import multi_dataflow_engine_pkg::*;
#(
  // Must match the package CNT_LEN, which sizes the control/flag structs.
  parameter int CNT_LEN = multi_dataflow_engine_pkg::CNT_LEN
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  ctrl_engine_t          ctrl_i,
  output flags_engine_t         flags_o,
  output ctrl_kernel_adapter_t  kernel_ctrl_o,
  input  flags_kernel_adapter_t kernel_flags_i,
  input  logic                  in_pel_valid_i,
  output logic                  in_pel_ready_o,
  input  logic [31:0]           in_pel_data_i,
  input  logic                  in_size_valid_i,
  output logic                  in_size_ready_o,
  input  logic [31:0]           in_size_data_i,
  output logic                  k_in_pel_valid_o,
  input  logic                  k_in_pel_ready_i,
  output logic [31:0]           k_in_pel_data_o,
  output logic                  k_in_size_valid_o,
  input  logic                  k_in_size_ready_i,
  output logic [31:0]           k_in_size_data_o,
  input  logic                  k_out_pel_valid_i,
  output logic                  k_out_pel_ready_o,
  input  logic [31:0]           k_out_pel_data_i,
  output logic                  out_pel_valid_o,
  input  logic                  out_pel_ready_i,
  output logic [31:0]           out_pel_data_o
);

  localparam int LCW = $clog2(CNT_LEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_FINISH} state_t;

  state_t         state_q, state_d;
  logic [LCW-1:0] cnt_q, cnt_d;
  logic [LCW-1:0] limit_q, limit_d;
  logic           kdone_q, kdone_d;

  logic           active;
  logic           pass_en;
  logic           out_en;
  logic           out_hs;
  logic [LCW-1:0] cnt_inc;
  logic           kernel_idle_unused;

  // The adapter's idle flag carries no information the sequencing needs.
  assign kernel_idle_unused = kernel_flags_i.idle;

  // clear outranks enable, so a clearing cycle never moves data.
  assign active  = ctrl_i.enable & ~ctrl_i.clear;
  assign pass_en = active & (state_q == S_RUN);
  assign out_en  = pass_en & (cnt_q < limit_q);

  assign k_in_pel_valid_o  = pass_en & in_pel_valid_i;
  assign k_in_pel_data_o   = pass_en ? in_pel_data_i : 32'd0;
  assign in_pel_ready_o    = pass_en & k_in_pel_ready_i;
  assign k_in_size_valid_o = pass_en & in_size_valid_i;
  assign k_in_size_data_o  = pass_en ? in_size_data_i : 32'd0;
  assign in_size_ready_o   = pass_en & k_in_size_ready_i;

  // Output stream is gated by the remaining budget so the limit is a hard cap.
  assign out_pel_valid_o   = out_en & k_out_pel_valid_i;
  assign out_pel_data_o    = out_en ? k_out_pel_data_i : 32'd0;
  assign k_out_pel_ready_o = out_en & out_pel_ready_i;

  assign out_hs  = out_pel_valid_o & out_pel_ready_i;
  assign cnt_inc = cnt_q + {{(LCW-1){1'b0}}, out_hs};

  assign flags_o.cnt_out_pel = cnt_q;
  assign flags_o.done        = (state_q == S_FINISH);
  assign flags_o.ready       = (state_q == S_IDLE);
  assign kernel_ctrl_o.start = active & (state_q == S_START);

  // Next-state logic; disable freezes everything, clear wipes the job.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    limit_d = limit_q;
    kdone_d = kdone_q;
    if (ctrl_i.clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      limit_d = '0;
      kdone_d = 1'b0;
    end else if (ctrl_i.enable) begin
      case (state_q)
        S_IDLE: begin
          if (ctrl_i.start) begin
            limit_d = ctrl_i.cnt_limit_out_pel;
            cnt_d   = '0;
            if (ctrl_i.cnt_limit_out_pel == '0) begin
              state_d = S_FINISH;
            end else begin
              state_d = S_START;
              kdone_d = 1'b0;
            end
          end
        end
        S_START: begin
          kdone_d = kdone_q | kernel_flags_i.done;
          if (kernel_flags_i.ready) state_d = S_RUN;
        end
        S_RUN: begin
          cnt_d   = cnt_inc;
          kdone_d = kdone_q | kernel_flags_i.done;
          // Look at the post-increment count so the last beat finishes without a bubble.
          if ((cnt_inc == limit_q) && kdone_d) state_d = S_FINISH;
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      limit_q <= '0;
      kdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
      kdone_q <= kdone_d;
    end
  end

endmodule

// File: tb/tb_multi_dataflow_engine.sv
// Bench for multi_dataflow_engine: job-level reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
// All inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_multi_dataflow_engine;
  import multi_dataflow_engine_pkg::*;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  ctrl_engine_t          ctrl_i;
  flags_engine_t         flags_o;
  ctrl_kernel_adapter_t  kernel_ctrl_o;
  flags_kernel_adapter_t kernel_flags_i;
  logic        in_pel_valid_i, in_pel_ready_o;
  logic [31:0] in_pel_data_i;
  logic        in_size_valid_i, in_size_ready_o;
  logic [31:0] in_size_data_i;
  logic        k_in_pel_valid_o, k_in_pel_ready_i;
  logic [31:0] k_in_pel_data_o;
  logic        k_in_size_valid_o, k_in_size_ready_i;
  logic [31:0] k_in_size_data_o;
  logic        k_out_pel_valid_i, k_out_pel_ready_o;
  logic [31:0] k_out_pel_data_i;
  logic        out_pel_valid_o, out_pel_ready_i;
  logic [31:0] out_pel_data_o;

  multi_dataflow_engine dut (
    .clk_i(clk_i), .rst_i(rst_i), .ctrl_i(ctrl_i), .flags_o(flags_o),
    .kernel_ctrl_o(kernel_ctrl_o), .kernel_flags_i(kernel_flags_i),
    .in_pel_valid_i(in_pel_valid_i), .in_pel_ready_o(in_pel_ready_o), .in_pel_data_i(in_pel_data_i),
    .in_size_valid_i(in_size_valid_i), .in_size_ready_o(in_size_ready_o), .in_size_data_i(in_size_data_i),
    .k_in_pel_valid_o(k_in_pel_valid_o), .k_in_pel_ready_i(k_in_pel_ready_i), .k_in_pel_data_o(k_in_pel_data_o),
    .k_in_size_valid_o(k_in_size_valid_o), .k_in_size_ready_i(k_in_size_ready_i), .k_in_size_data_o(k_in_size_data_o),
    .k_out_pel_valid_i(k_out_pel_valid_i), .k_out_pel_ready_o(k_out_pel_ready_o), .k_out_pel_data_i(k_out_pel_data_i),
    .out_pel_valid_o(out_pel_valid_o), .out_pel_ready_i(out_pel_ready_i), .out_pel_data_o(out_pel_data_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passed = 0;

  // Job-level model: a job is either absent, waiting for the kernel to accept start,
  // streaming, or reporting completion for one cycle.
  logic m_busy = 1'b0, m_started = 1'b0, m_fin = 1'b0, m_kdone = 1'b0;
  int   m_cnt = 0, m_lim = 0;

  // Event tallies observed on the DUT, compared against hand-computed numbers.
  int hs_cnt = 0, done_cnt = 0, kstart_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_cycle();
    logic act, pass, room, hs, kd;
    if (rst_i) begin
      m_busy = 0; m_started = 0; m_fin = 0; m_kdone = 0; m_cnt = 0; m_lim = 0;
    end
    act  = ctrl_i.enable && !ctrl_i.clear;
    pass = act && m_busy && m_started;
    room = (m_cnt < m_lim);
    hs   = pass && room && k_out_pel_valid_i && out_pel_ready_i;

    chk("flags_ready", flags_o.ready, !m_busy && !m_fin);
    chk("flags_done", flags_o.done, m_fin);
    chk("flags_cnt", flags_o.cnt_out_pel, m_cnt);
    chk("kernel_start", kernel_ctrl_o.start, act && m_busy && !m_started);
    chk("k_in_pel_valid", k_in_pel_valid_o, pass && in_pel_valid_i);
    chk("k_in_pel_data", k_in_pel_data_o, pass ? in_pel_data_i : 32'd0);
    chk("in_pel_ready", in_pel_ready_o, pass && k_in_pel_ready_i);
    chk("k_in_size_valid", k_in_size_valid_o, pass && in_size_valid_i);
    chk("k_in_size_data", k_in_size_data_o, pass ? in_size_data_i : 32'd0);
    chk("in_size_ready", in_size_ready_o, pass && k_in_size_ready_i);
    chk("out_pel_valid", out_pel_valid_o, pass && room && k_out_pel_valid_i);
    chk("out_pel_data", out_pel_data_o, (pass && room) ? k_out_pel_data_i : 32'd0);
    chk("k_out_pel_ready", k_out_pel_ready_o, pass && room && out_pel_ready_i);

    hs_cnt     += int'(out_pel_valid_o && out_pel_ready_i);
    done_cnt   += int'(flags_o.done);
    kstart_cnt += int'(kernel_ctrl_o.start);

    if (!rst_i) begin
      if (ctrl_i.clear) begin
        m_busy = 0; m_started = 0; m_fin = 0; m_kdone = 0; m_cnt = 0; m_lim = 0;
      end else if (ctrl_i.enable) begin
        if (m_fin) begin
          m_fin = 0;
        end else if (!m_busy) begin
          if (ctrl_i.start) begin
            m_lim = int'(ctrl_i.cnt_limit_out_pel);
            m_cnt = 0;
            if (m_lim == 0) m_fin = 1;
            else begin m_busy = 1; m_started = 0; m_kdone = 0; end
          end
        end else begin
          kd = m_kdone || kernel_flags_i.done;
          m_kdone = kd;
          if (!m_started) m_started = kernel_flags_i.ready;
          else begin
            m_cnt += int'(hs);
            if (m_cnt == m_lim && kd) begin m_busy = 0; m_started = 0; m_fin = 1; end
          end
        end
      end
    end
  endtask

  // One clock: compare on the falling edge, then re-drive just after the rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      model_cycle();
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic start_job(input int lim);
    ctrl_i.start = 1'b1;
    ctrl_i.cnt_limit_out_pel = CW'(lim);
    tick();
    ctrl_i.start = 1'b0;
  endtask

  task automatic enter_run();
    kernel_flags_i.ready = 1'b1;
    tick();
    kernel_flags_i.ready = 1'b0;
  endtask

  task automatic rand_env();
    kernel_flags_i.ready = 1'($urandom_range(0, 1));
    kernel_flags_i.done  = ($urandom_range(0, 5) == 0);
    kernel_flags_i.idle  = 1'($urandom_range(0, 1));
    in_pel_valid_i    = 1'($urandom_range(0, 1));
    in_pel_data_i     = $urandom;
    in_size_valid_i   = 1'($urandom_range(0, 1));
    in_size_data_i    = $urandom;
    k_in_pel_ready_i  = 1'($urandom_range(0, 1));
    k_in_size_ready_i = 1'($urandom_range(0, 1));
    k_out_pel_valid_i = 1'($urandom_range(0, 1));
    k_out_pel_data_i  = $urandom;
    out_pel_ready_i   = ($urandom_range(0, 3) != 0);
  endtask

  int hs0, d0, ks0;

  initial begin
    rst_i = 1'b1;
    ctrl_i = '0;
    kernel_flags_i = '0;
    in_pel_valid_i = 1'b1;  in_pel_data_i = 32'h1111_0000;
    in_size_valid_i = 1'b1; in_size_data_i = 32'h2222_0000;
    k_in_pel_ready_i = 1'b1; k_in_size_ready_i = 1'b0;
    k_out_pel_valid_i = 1'b0; k_out_pel_data_i = 32'd0;
    out_pel_ready_i = 1'b0;

    // Reset values.
    #1;
    chk("rst_ready", flags_o.ready, 1);
    chk("rst_done", flags_o.done, 0);
    chk("rst_cnt", flags_o.cnt_out_pel, 0);
    chk("rst_kstart", kernel_ctrl_o.start, 0);
    chk("rst_in_ready", in_pel_ready_o, 0);
    tick(2);
    rst_i = 1'b0;
    ctrl_i.enable = 1'b1;
    tick();

    // Limit 4, sink always ready, four beats then kernel done.
    start_job(4);
    chk("s30_kstart_latency", kernel_ctrl_o.start, 1);
    enter_run();
    out_pel_ready_i = 1'b1;
    hs0 = hs_cnt; d0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      k_out_pel_valid_i = 1'b1;
      k_out_pel_data_i  = 32'hA0 + 32'(i);
      tick();
      chk("s30_cnt_step", flags_o.cnt_out_pel, 32'(i + 1));
    end
    k_out_pel_valid_i = 1'b0;
    kernel_flags_i.done = 1'b1;
    tick();
    kernel_flags_i.done = 1'b0;
    chk("s30_done_pulse", flags_o.done, 1);
    tick();
    chk("s30_done_single", flags_o.done, 0);
    chk("s30_ready_after", flags_o.ready, 1);
    chk("s30_cnt_hold", flags_o.cnt_out_pel, 4);
    chk("s30_handshakes", hs_cnt - hs0, 4);
    chk("s30_done_count", done_cnt - d0, 1);

    // Limit 3, kernel keeps offering beats past the limit.
    start_job(3);
    enter_run();
    hs0 = hs_cnt;
    k_out_pel_valid_i = 1'b1;
    k_out_pel_data_i = 32'hBEEF;
    tick(5);
    chk("s31_cnt_capped", flags_o.cnt_out_pel, 3);
    chk("s31_kout_ready_off", k_out_pel_ready_o, 0);
    chk("s31_out_valid_off", out_pel_valid_o, 0);
    chk("s31_handshakes", hs_cnt - hs0, 3);
    k_out_pel_valid_i = 1'b0;
    kernel_flags_i.done = 1'b1;
    tick();
    kernel_flags_i.done = 1'b0;
    chk("s31_done_pulse", flags_o.done, 1);
    tick();

    // Limit 0 goes straight to completion without starting the kernel.
    ks0 = kstart_cnt; d0 = done_cnt;
    start_job(0);
    chk("s32_done_next", flags_o.done, 1);
    chk("s32_no_kstart", kernel_ctrl_o.start, 0);
    tick();
    chk("s32_ready", flags_o.ready, 1);
    chk("s32_cnt_zero", flags_o.cnt_out_pel, 0);
    chk("s32_kstart_count", kstart_cnt - ks0, 0);
    chk("s32_done_count", done_cnt - d0, 1);

    // Enable dropped mid-run freezes the job.
    start_job(4);
    enter_run();
    k_out_pel_valid_i = 1'b1;
    tick(2);
    chk("s33_cnt_before", flags_o.cnt_out_pel, 2);
    ctrl_i.enable = 1'b0;
    hs0 = hs_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s33_cnt_frozen", flags_o.cnt_out_pel, 2);
    end
    chk("s33_no_hs", hs_cnt - hs0, 0);
    ctrl_i.enable = 1'b1;
    tick(2);
    chk("s33_cnt_after", flags_o.cnt_out_pel, 4);
    k_out_pel_valid_i = 1'b0;
    kernel_flags_i.done = 1'b1;
    tick();
    kernel_flags_i.done = 1'b0;
    chk("s33_done_pulse", flags_o.done, 1);
    tick();

    // Kernel done arrives three cycles before the last beat.
    start_job(2);
    enter_run();
    k_out_pel_valid_i = 1'b1;
    kernel_flags_i.done = 1'b1;
    tick();
    kernel_flags_i.done = 1'b0;
    k_out_pel_valid_i = 1'b0;
    tick(2);
    chk("s34_not_done_yet", flags_o.done, 0);
    k_out_pel_valid_i = 1'b1;
    tick();
    chk("s34_done_after_last", flags_o.done, 1);
    chk("s34_cnt", flags_o.cnt_out_pel, 2);
    k_out_pel_valid_i = 1'b0;
    tick();
    chk("s34_ready", flags_o.ready, 1);

    // Clear mid-run, then reset mid-start: both abort silently.
    d0 = done_cnt;
    start_job(4);
    enter_run();
    k_out_pel_valid_i = 1'b1;
    tick();
    chk("s35_cnt_one", flags_o.cnt_out_pel, 1);
    ctrl_i.clear = 1'b1;
    tick();
    ctrl_i.clear = 1'b0;
    k_out_pel_valid_i = 1'b0;
    chk("s35_clear_ready", flags_o.ready, 1);
    chk("s35_clear_cnt", flags_o.cnt_out_pel, 0);
    start_job(4);
    chk("s35_in_start", kernel_ctrl_o.start, 1);
    rst_i = 1'b1;
    #1;
    chk("s35_rst_kstart", kernel_ctrl_o.start, 0);
    chk("s35_rst_ready", flags_o.ready, 1);
    tick();
    rst_i = 1'b0;
    tick();
    chk("s35_idle_after", flags_o.ready, 1);
    chk("s35_cnt_after", flags_o.cnt_out_pel, 0);
    chk("s35_no_done", done_cnt - d0, 0);

    // Randomized soak against the model.
    for (int c = 0; c < 4000; c++) begin
      rand_env();
      ctrl_i.enable = ($urandom_range(0, 9) != 0);
      ctrl_i.clear  = ($urandom_range(0, 149) == 0);
      ctrl_i.start  = ($urandom_range(0, 3) == 0);
      ctrl_i.cnt_limit_out_pel = CW'($urandom_range(0, 6));
      rst_i = ($urandom_range(0, 499) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
